// File: rtl/ew_mat_pkg.sv
// rtl/ew_mat_pkg.sv - shared op codes, FSM states and helpers for the elementwise matrix unit
package ew_mat_pkg;

    typedef enum logic [1:0] {
        OP_MUL = 2'b00,
        OP_ADD = 2'b01,
        OP_SUB = 2'b10
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/ew_mat_mult_seq_if.sv
// rtl/ew_mat_mult_seq_if.sv - operand/result handshake bundle for ew_mat_mult_seq
interface ew_mat_mult_seq_if #(
    parameter int N = 3,
    parameter int W = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [1:0]             op;
    logic [N*N*W-1:0]       A;
    logic [N*N*W-1:0]       B;
    logic                   out_valid;
    logic                   out_ready;
    logic [N*N*2*W-1:0]     Res;

    modport master (
        output in_valid, op, A, B, out_ready,
        input  in_ready, out_valid, Res
    );

    modport slave (
        input  in_valid, op, A, B, out_ready,
        output in_ready, out_valid, Res
    );
endinterface

// File: rtl/ew_lane.sv
// rtl/ew_lane.sv - single-element ALU: mul/add/sub on operands widened to 2W
module ew_lane
    import ew_mat_pkg::*;
#(
    parameter int W      = 8,
    parameter int SIGNED = 0
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [1:0]     op,
    output logic [2*W-1:0] r
);

    logic [2*W-1:0] a_x;
    logic [2*W-1:0] b_x;

    // Widen both operands, then compute modulo 2^(2W); the low 2W bits of a
    // product of sign-extended operands are the exact signed product.
    always_comb begin
        if (SIGNED != 0) begin
            a_x = {{W{a[W-1]}}, a};
            b_x = {{W{b[W-1]}}, b};
        end else begin
            a_x = {{W{1'b0}}, a};
            b_x = {{W{1'b0}}, b};
        end
        case (op_t'(op))
            OP_ADD:  r = a_x + b_x;
            OP_SUB:  r = a_x - b_x;
            default: r = a_x * b_x;
        endcase
    end

endmodule

// File: rtl/ew_mat_mult_seq.sv
// rtl/ew_mat_mult_seq.sv - sequential NxN elementwise matrix op, LANES elements per clock
module ew_mat_mult_seq
    import ew_mat_pkg::*;
#(
    parameter int N      = 3,
    parameter int W      = 8,
    parameter int LANES  = 1,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    ew_mat_mult_seq_if.slave bus
);

    localparam int NE         = N * N;
    localparam int EW         = 2 * W;
    localparam int IW         = $clog2(NE + LANES);
    localparam int RUN_CYCLES = ceil_div(NE, LANES);
    // idx value during the final RUN cycle, i.e. the cycle that writes element NE-1
    localparam int LAST_IDX   = (RUN_CYCLES - 1) * LANES;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [NE*W-1:0]     a_q, a_d;
    logic [NE*W-1:0]     b_q, b_d;
    logic [1:0]          op_q, op_d;
    logic [NE*EW-1:0]    res_q, res_d;

    logic                in_ready;
    logic                out_valid;
    logic                accept;
    logic                last_run;

    logic [W-1:0]        lane_a [LANES];
    logic [W-1:0]        lane_b [LANES];
    logic [EW-1:0]       lane_r [LANES];

    assign accept   = bus.in_valid && in_ready;
    assign last_run = (idx_q == IW'(LAST_IDX));

    // State register and datapath flops; reset discards any partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
        end
    end

    // Next state: DONE with out_ready and a waiting operand set jumps straight to RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_RUN;
            S_RUN:  if (last_run) state_d = S_DONE;
            S_DONE: if (bus.out_ready) state_d = accept ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs: ready in IDLE, or in DONE when the result is being taken.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: in_ready = 1'b1;
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = bus.out_ready;
            end
            default: ;
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.Res       = res_q;

    // Route the current window of operand elements to the lanes; lanes past NE-1 idle at zero.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_a[l] = '0;
            lane_b[l] = '0;
            if (int'(idx_q) + l < NE) begin
                lane_a[l] = a_q[(int'(idx_q) + l) * W +: W];
                lane_b[l] = b_q[(int'(idx_q) + l) * W +: W];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            ew_lane #(
                .W      (W),
                .SIGNED (SIGNED)
            ) u_lane (
                .a  (lane_a[g]),
                .b  (lane_b[g]),
                .op (op_q),
                .r  (lane_r[g])
            );
        end
    endgenerate

    // Operand capture on accept; in RUN, write one window of results and advance idx.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        op_d  = op_q;
        idx_d = idx_q;
        res_d = res_q;
        if (accept) begin
            a_d   = bus.A;
            b_d   = bus.B;
            op_d  = bus.op;
            idx_d = '0;
        end else if (state_q == S_RUN) begin
            idx_d = idx_q + IW'(LANES);
            for (int l = 0; l < LANES; l++) begin
                if (int'(idx_q) + l < NE) begin
                    res_d[(int'(idx_q) + l) * EW +: EW] = lane_r[l];
                end
            end
        end
    end

endmodule

// File: tb/tb_ew_mat_mult_seq.sv
// tb/tb_ew_mat_mult_seq.sv - directed self-checking bench for ew_mat_mult_seq
module tb_ew_mat_mult_seq;

    logic clk;
    logic rst;
    int   errs;
    int   checks;

    ew_mat_mult_seq_if #(.N(3), .W(8)) if0 ();
    ew_mat_mult_seq_if #(.N(3), .W(8)) if1 ();
    ew_mat_mult_seq_if #(.N(3), .W(8)) if2 ();

    ew_mat_mult_seq #(.N(3), .W(8), .LANES(1), .SIGNED(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    ew_mat_mult_seq #(.N(3), .W(8), .LANES(1), .SIGNED(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    ew_mat_mult_seq #(.N(3), .W(8), .LANES(4), .SIGNED(0)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [71:0]  va, vb, vff;
    logic [143:0] exp_mul, exp_add, exp_sub;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input int d, input logic v, input logic [1:0] o,
                            input logic [71:0] a, input logic [71:0] b);
        case (d)
            0: begin if0.in_valid = v; if0.op = o; if0.A = a; if0.B = b; end
            1: begin if1.in_valid = v; if1.op = o; if1.A = a; if1.B = b; end
            default: begin if2.in_valid = v; if2.op = o; if2.A = a; if2.B = b; end
        endcase
    endtask

    task automatic set_ordy(input int d, input logic v);
        case (d)
            0: if0.out_ready = v;
            1: if1.out_ready = v;
            default: if2.out_ready = v;
        endcase
    endtask

    function automatic logic ov_of(input int d);
        case (d)
            0: return if0.out_valid;
            1: return if1.out_valid;
            default: return if2.out_valid;
        endcase
    endfunction

    function automatic logic ir_of(input int d);
        case (d)
            0: return if0.in_ready;
            1: return if1.in_ready;
            default: return if2.in_ready;
        endcase
    endfunction

    function automatic logic [143:0] res_of(input int d);
        case (d)
            0: return if0.Res;
            1: return if1.Res;
            default: return if2.Res;
        endcase
    endfunction

    // Accept one set from IDLE, then wait (bounded) for out_valid; out_ready stays low.
    task automatic transact(input int d, input logic [1:0] o, input logic [71:0] a,
                            input logic [71:0] b, output int lat, output logic [143:0] res);
        set_ordy(d, 1'b0);
        drive_in(d, 1'b1, o, a, b);
        tick();
        lat = 1;
        drive_in(d, 1'b0, 2'b00, '0, '0);
        while (!ov_of(d) && lat < 60) begin
            tick();
            lat++;
        end
        res = res_of(d);
    endtask

    task automatic release_out(input int d);
        set_ordy(d, 1'b1);
        tick();
        set_ordy(d, 1'b0);
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ir_of(d) !== 1'b1) begin
                errs++; $display("FAIL reset_in_ready dut%0d: got %b want 1", d, ir_of(d));
            end
            checks++;
            if (ov_of(d) !== 1'b0) begin
                errs++; $display("FAIL reset_out_valid dut%0d: got %b want 0", d, ov_of(d));
            end
            checks++;
            if (res_of(d) !== 144'd0) begin
                errs++; $display("FAIL reset_res dut%0d: got %h want 0", d, res_of(d));
            end
        end
    endtask

    task automatic test_mul();
        int lat; logic [143:0] r;
        transact(0, 2'b00, va, vb, lat, r);
        checks++;
        if (lat !== 10) begin errs++; $display("FAIL mul_latency: got %0d want 10", lat); end
        checks++;
        if (r !== exp_mul) begin errs++; $display("FAIL mul_res: got %h want %h", r, exp_mul); end
        release_out(0);
    endtask

    task automatic test_add_sub();
        int lat; logic [143:0] r;
        transact(0, 2'b01, va, vb, lat, r);
        checks++;
        if (r !== exp_add) begin errs++; $display("FAIL add_res: got %h want %h", r, exp_add); end
        release_out(0);
        transact(0, 2'b10, va, vb, lat, r);
        checks++;
        if (r !== exp_sub) begin errs++; $display("FAIL sub_res: got %h want %h", r, exp_sub); end
        release_out(0);
        transact(0, 2'b11, va, vb, lat, r);
        checks++;
        if (r !== exp_mul) begin errs++; $display("FAIL op11_res: got %h want %h", r, exp_mul); end
        release_out(0);
    endtask

    task automatic test_all_ones();
        int lat; logic [143:0] r;
        transact(0, 2'b00, vff, vff, lat, r);
        checks++;
        if (r !== {9{16'hFE01}}) begin errs++; $display("FAIL ones_unsigned: got %h want fe01 x9", r); end
        release_out(0);
        transact(1, 2'b00, vff, vff, lat, r);
        checks++;
        if (r !== {9{16'h0001}}) begin errs++; $display("FAIL ones_signed: got %h want 0001 x9", r); end
        release_out(1);
        transact(1, 2'b10, va, vb, lat, r);
        checks++;
        if (r !== exp_sub) begin errs++; $display("FAIL signed_sub: got %h want %h", r, exp_sub); end
        release_out(1);
    endtask

    task automatic test_lanes4();
        int lat; logic [143:0] r;
        transact(2, 2'b00, va, vb, lat, r);
        checks++;
        if (lat !== 4) begin errs++; $display("FAIL lanes4_latency: got %0d want 4", lat); end
        checks++;
        if (r !== exp_mul) begin errs++; $display("FAIL lanes4_mul: got %h want %h", r, exp_mul); end
        release_out(2);
        transact(2, 2'b01, va, vb, lat, r);
        checks++;
        if (lat !== 4) begin errs++; $display("FAIL lanes4_add_latency: got %0d want 4", lat); end
        checks++;
        if (r !== exp_add) begin errs++; $display("FAIL lanes4_add: got %h want %h", r, exp_add); end
        release_out(2);
    endtask

    task automatic test_back_to_back();
        int lat; logic [143:0] r;
        transact(0, 2'b00, va, vb, lat, r);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (if0.out_valid !== 1'b1) begin errs++; $display("FAIL bp_out_valid c%0d: got %b want 1", i, if0.out_valid); end
            checks++;
            if (if0.Res !== exp_mul) begin errs++; $display("FAIL bp_res c%0d: got %h want %h", i, if0.Res, exp_mul); end
            checks++;
            if (if0.in_ready !== 1'b0) begin errs++; $display("FAIL bp_in_ready c%0d: got %b want 0", i, if0.in_ready); end
        end
        set_ordy(0, 1'b1);
        drive_in(0, 1'b1, 2'b01, va, vb);
        #1;
        checks++;
        if (if0.in_ready !== 1'b1) begin errs++; $display("FAIL b2b_in_ready: got %b want 1", if0.in_ready); end
        tick();
        lat = 1;
        drive_in(0, 1'b0, 2'b00, '0, '0);
        set_ordy(0, 1'b0);
        checks++;
        if (if0.out_valid !== 1'b0) begin errs++; $display("FAIL b2b_out_valid_drop: got %b want 0", if0.out_valid); end
        checks++;
        if (if0.in_ready !== 1'b0) begin errs++; $display("FAIL b2b_run_in_ready: got %b want 0", if0.in_ready); end
        while (!if0.out_valid && lat < 60) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== 10) begin errs++; $display("FAIL b2b_latency: got %0d want 10", lat); end
        checks++;
        if (if0.Res !== exp_add) begin errs++; $display("FAIL b2b_res: got %h want %h", if0.Res, exp_add); end
        release_out(0);
    endtask

    task automatic test_reset_mid_run();
        int lat; logic [143:0] r;
        drive_in(0, 1'b1, 2'b00, va, vb);
        tick();
        drive_in(0, 1'b0, 2'b00, '0, '0);
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        checks++;
        if (if0.Res !== 144'd0) begin errs++; $display("FAIL midrst_res: got %h want 0", if0.Res); end
        checks++;
        if (if0.out_valid !== 1'b0) begin errs++; $display("FAIL midrst_out_valid: got %b want 0", if0.out_valid); end
        checks++;
        if (if0.in_ready !== 1'b1) begin errs++; $display("FAIL midrst_in_ready: got %b want 1", if0.in_ready); end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (if0.out_valid !== 1'b0) begin errs++; $display("FAIL postrst_out_valid: got %b want 0", if0.out_valid); end
        transact(0, 2'b01, va, vb, lat, r);
        checks++;
        if (lat !== 10) begin errs++; $display("FAIL postrst_latency: got %0d want 10", lat); end
        checks++;
        if (r !== exp_add) begin errs++; $display("FAIL postrst_res: got %h want %h", r, exp_add); end
        release_out(0);
    endtask

    initial begin
        errs   = 0;
        checks = 0;
        rst    = 1'b1;
        for (int d = 0; d < 3; d++) begin
            drive_in(d, 1'b0, 2'b00, '0, '0);
            set_ordy(d, 1'b0);
        end
        for (int i = 0; i < 9; i++) begin
            va[(8 - i) * 8 +: 8] = 8'(i + 1);
            vb[(8 - i) * 8 +: 8] = 8'(i + 10);
        end
        vff     = {9{8'hFF}};
        exp_mul = {16'd10, 16'd22, 16'd36, 16'd52, 16'd70, 16'd90, 16'd112, 16'd136, 16'd162};
        exp_add = {16'd11, 16'd13, 16'd15, 16'd17, 16'd19, 16'd21, 16'd23, 16'd25, 16'd27};
        exp_sub = {9{16'hFFF7}};
        tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_mul();
        test_add_sub();
        test_all_ones();
        test_lanes4();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
